// File: rtl/fifo_pkg.sv
// Shared types for the FIFO serial transmitter.
//   tx_state_e    : transmitter FSM states (PARITY exists even when parity is not built)
//   TX_IDLE_LEVEL : line level driven while no frame is in flight
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int TX_IDLE_LEVEL = 1;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Baud counter for the serial transmitter.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   run   : counter advances while high, holds at zero while low
//   tick  : high in the last clk cycle of each bit period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; CLKS_PER_BIT = 1 ticks every cycle.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a push/pop FIFO and shifts them out LSB-first:
// start bit (0), DATA_WIDTH data bits, optional even-parity bit, stop bit (1).
// Optional feature: define FIFO_SERIAL_TX_PARITY_EN to insert the parity bit.
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset
//   enable     : permits starting a new frame, sampled in IDLE only
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head word, valid while fifo_empty = 0
//   fifo_pop   : one-cycle pop strobe (LOAD state only)
//   tx_serial  : serial line, idle high
//   tx_busy    : high in every state except IDLE
//   tx_done    : pulse in the last cycle of the stop bit
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_e             state;
  tx_state_e             state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  run;
  logic                  tick;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                  parity;
`endif

  // Bit timing runs only while a bit is on the line.
  assign run = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (tick) state_next = DATA;
      DATA: begin
        if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    tx_serial = 1'(TX_IDLE_LEVEL);
    tx_busy   = 1'b1;
    tx_done   = 1'b0;
    case (state)
      IDLE:   tx_busy = 1'b0;
      START:  tx_serial = 1'b0;
      DATA:   tx_serial = shreg[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: tx_serial = parity;
`endif
      STOP:   tx_done = tick;
      default: ;
    endcase
  end

  // Gate with reset so a reset arriving in LOAD never consumes a word.
  assign fifo_pop = (state == LOAD) && !reset;

  // Shift register and bit counter; the head word is captured on the pop edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          shreg   <= fifo_data;
          bit_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          parity  <= ^fifo_data;
`endif
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
